// File: rtl/or_loop_pkg.sv
// Shared types and helpers for the OR-loop storage element.
// The state enum and the once-per-round width update live here so the FSM
// and any future variant agree on the same rules.
package or_loop_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    CIRC    = 2'd2,
    LATCHED = 2'd3
  } state_e;

  // Width update applied once per round. A pulse wider than half a round
  // grows toward a full loop; otherwise it shrinks toward nothing. Because
  // the loop length is odd, no pulse sits exactly at the midpoint.
  function automatic int unsigned round_update(input int unsigned w,
                                               input int unsigned loop_len,
                                               input int unsigned grow);
    int unsigned res;
    if (2 * w > loop_len) begin
      res = (w + grow > loop_len) ? loop_len : w + grow;
    end else begin
      res = (w > grow) ? w - grow : 0;
    end
    return res;
  endfunction

endpackage

// File: rtl/or_loop_sync.sv
// Two-flop input synchronizer for the OR-loop input.
// Only compiled when IN_SYNC_EN is defined; the default build feeds the
// loop input straight into the FSM and has no use for this module.
`ifdef IN_SYNC_EN
module or_loop_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; both clear to 0 so no false pulse after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`endif

// File: rtl/or_loop.sv
// OR gate with a buffered feedback loop, modelled at cycle level.
// A captured pulse of width w circulates with a round time of LOOP_LEN
// cycles; each round it widens (if more than half a round) or narrows,
// until it fills the loop (latched) or vanishes (idle).
// Optional macro IN_SYNC_EN: pass myin through a 2-flop synchronizer,
// adding two cycles of input latency.
module or_loop
  import or_loop_pkg::*;
#(
  parameter int unsigned LOOP_LEN = 29,
  parameter int unsigned GROW     = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic myin,
  input  logic fb_clr,
  output logic myout,
  output logic latched,
  output logic busy
);

  localparam int unsigned W = $clog2(LOOP_LEN + 1);
  localparam logic [W-1:0] LEN_W  = W'(LOOP_LEN);
  localparam logic [W-1:0] LAST_W = W'(LOOP_LEN - 1);

  logic in_q;

`ifdef IN_SYNC_EN
  or_loop_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (myin),
    .q_o   (in_q)
  );
`else
  assign in_q = myin;
`endif

  state_e       state_q;
  logic [W-1:0] w_q;
  logic [W-1:0] phase_q;
  logic         myout_q;
  logic         latched_q;
  logic         busy_q;

  logic         head_d;
  logic [W-1:0] w_ext_d;
  logic [W-1:0] w_upd_d;

  // Loop-head value, the width after any OR-extension by a late input
  // pulse, and the width that results from the end-of-round update.
  always_comb begin
    head_d  = 1'b0;
    w_ext_d = w_q;
    w_upd_d = w_q;
    case (state_q)
      IDLE:             head_d = 1'b0;
      CAPTURE, LATCHED: head_d = 1'b1;
      CIRC: begin
        head_d = (phase_q < w_q) | in_q;
        if (in_q && (phase_q >= w_q)) begin
          w_ext_d = phase_q + 1'b1;
        end
        w_upd_d = W'(round_update(32'(w_ext_d), LOOP_LEN, GROW));
      end
      default: head_d = 1'b0;
    endcase
  end

  // Single FSM: state, w/phase counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      w_q       <= '0;
      phase_q   <= '0;
      myout_q   <= 1'b0;
      latched_q <= 1'b0;
      busy_q    <= 1'b0;
    end else if (fb_clr) begin
      state_q   <= IDLE;
      w_q       <= '0;
      phase_q   <= '0;
      myout_q   <= 1'b0;
      latched_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      myout_q <= head_d;
      case (state_q)
        IDLE: begin
          if (in_q) begin
            state_q <= CAPTURE;
            w_q     <= W'(1);
          end
        end
        CAPTURE: begin
          if (in_q) begin
            if (w_q < LEN_W) w_q <= w_q + 1'b1;
          end else if (w_q >= LEN_W) begin
            state_q   <= LATCHED;
            latched_q <= 1'b1;
          end else begin
            state_q <= CIRC;
            phase_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        CIRC: begin
          if (phase_q == LAST_W) begin
            phase_q <= '0;
            w_q     <= w_upd_d;
            if (w_upd_d == LEN_W) begin
              state_q   <= LATCHED;
              latched_q <= 1'b1;
              busy_q    <= 1'b0;
            end else if (w_upd_d == '0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
            w_q     <= w_ext_d;
          end
        end
        LATCHED: begin
          state_q <= LATCHED;
        end
        default: begin
          state_q <= IDLE;
          w_q     <= '0;
          phase_q <= '0;
        end
      endcase
    end
  end

  assign myout   = myout_q;
  assign latched = latched_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_or_loop.sv
// Self-checking bench for or_loop (LOOP_LEN=29, GROW=1, no input sync).
// Directed scenarios followed by randomized pulses, each cycle compared
// against a behavioural model of the loop rules.
module tb_or_loop;

  localparam int L = 29;
  localparam int G = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic myin = 1'b0;
  logic fb_clr = 1'b0;
  logic myout, latched, busy;

  or_loop #(.LOOP_LEN(L), .GROW(G)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .myin    (myin),
    .fb_clr  (fb_clr),
    .myout   (myout),
    .latched (latched),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the pulse is described by its mode, width and position
  // in the round; outputs are what the loop node shows after the next edge.
  localparam int M_IDLE = 0, M_CAP = 1, M_CIRC = 2, M_LAT = 3;
  int m_mode = M_IDLE;
  int m_w = 0;
  int m_pos = 0;
  bit m_out = 1'b0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_w = 0; m_pos = 0; m_out = 1'b0;
  endtask

  task automatic model_step(input bit in_v, input bit clr_v);
    if (clr_v) begin
      model_reset();
    end else if (m_mode == M_IDLE) begin
      m_out = 1'b0;
      if (in_v) begin m_mode = M_CAP; m_w = 1; end
    end else if (m_mode == M_CAP) begin
      m_out = 1'b1;
      if (in_v) m_w = imin(m_w + 1, L);
      else if (m_w >= L) m_mode = M_LAT;
      else begin m_mode = M_CIRC; m_pos = 0; end
    end else if (m_mode == M_CIRC) begin
      m_out = (m_pos < m_w) || in_v;
      if (in_v && m_pos >= m_w) m_w = m_pos + 1;
      m_pos = m_pos + 1;
      if (m_pos == L) begin
        m_pos = 0;
        m_w = (2 * m_w > L) ? imin(m_w + G, L) : imax(m_w - G, 0);
        if (m_w == L) m_mode = M_LAT;
        else if (m_w == 0) m_mode = M_IDLE;
      end
    end else begin
      m_out = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".myout"}, myout, m_out);
    check({tag, ".latched"}, latched, m_mode == M_LAT);
    check({tag, ".busy"}, busy, m_mode == M_CIRC);
  endtask

  // One clock cycle: drive inputs, advance model, sample 1 ns after the edge.
  task automatic tick(input logic in_v, input logic clr_v, input string tag);
    myin = in_v;
    fb_clr = clr_v;
    model_step(in_v, clr_v);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, tag);
  endtask

  task automatic pulse(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b1;
    myin = 1'b0;
    fb_clr = 1'b0;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    rst_n = 1'b1;
  endtask

  initial begin
    int width, gap, bound;
    do_reset("rst");
    idle(40, "quiet");
    $display("scenario 1: reset and quiet input");

    pulse(3, "p3");
    idle(130, "p3_rounds");
    check("p3_dead", busy, 1'b0);
    $display("scenario 2: 3-cycle pulse shrinks away");

    pulse(15, "p15");
    idle(14 * L + 20, "p15_rounds");
    check("p15_latched", latched, 1'b1);
    $display("scenario 3: 15-cycle pulse grows to latch");

    tick(1'b0, 1'b1, "clr_a");
    pulse(29, "p29");
    tick(1'b0, 1'b0, "p29_fall");
    check("p29_latched", latched, 1'b1);
    for (int i = 0; i < 20; i++) tick(i[0], 1'b0, "p29_toggle");
    check("p29_hold", myout, 1'b1);
    $display("scenario 4: full-loop pulse latches at once");

    tick(1'b0, 1'b1, "clr_b");
    check("clr_b_out", myout, 1'b0);
    pulse(14, "p14");
    idle(14 * L + 20, "p14_rounds");
    check("p14_dead", busy, 1'b0);
    $display("scenario 5: clear from latch, 14-cycle pulse dies");

    pulse(10, "p10");
    idle(6, "p10_circ");
    do_reset("rst_mid");
    idle(70, "after_rst");
    $display("scenario 6: reset mid-circulation");

    for (int it = 0; it < 40; it++) begin
      width = $urandom_range(1, 32);
      pulse(width, "rnd_pulse");
      gap = $urandom_range(0, 120);
      for (int c = 0; c < gap; c++)
        tick(($urandom_range(0, 99) < 3), ($urandom_range(0, 999) < 5), "rnd_gap");
      if ($urandom_range(0, 99) < 5) do_reset("rnd_rst");
      bound = 0;
      while (busy && bound < 1000) begin
        tick(1'b0, 1'b0, "rnd_settle");
        bound++;
      end
      check("rnd_settle_bound", busy, 1'b0);
      if (latched) tick(1'b0, 1'b1, "rnd_clr");
      $display("random pulse %0d: width %0d gap %0d", it, width, gap);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
